// File: rtl/dma_pkg.sv
// Shared DMA control-register definitions: FSM encoding, CTRL bit positions, default window.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dma_pkg;

   // Bus handshake FSM: idle, or holding ack until the requester drops req
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } creg_state_t;

   // CTRL word bit positions
   localparam int CTRL_START = 0;   // write 1 fires start_o, always reads 0
   localparam int CTRL_IEN   = 1;   // interrupt enable
   localparam int CTRL_DONE  = 2;   // sticky done, write-1-clears

   // Default address window of the block
   localparam logic [31:0] DMA_DEF_BASE_ADDR  = 32'hAFFF_FFC0;
   localparam logic [31:0] DMA_DEF_MATCH_MASK = 32'hFFFF_FFC0;

endpackage

// File: rtl/dma_win_decode.sv
// Address window match plus one-hot word-index decode for the DMA register bank.
// Latency: purely combinational.
// Backpressure: none; outputs follow adbus directly.
module dma_win_decode #(
   parameter logic [31:0] BASE_ADDR  = 32'hAFFF_FFC0,
   parameter logic [31:0] MATCH_MASK = 32'hFFFF_FFC0,
   parameter int          NUM_REGS   = 4,
   parameter int          FIRST_IDX  = 12
) (
   input  logic [31:0]         adbus,
   output logic                hit,
   output logic [NUM_REGS-1:0] onehot
);

   // Index bounds held one bit wider so FIRST_IDX+NUM_REGS == 16 does not wrap
   localparam logic [4:0] IDX_LO = 5'(FIRST_IDX);
   localparam logic [4:0] IDX_HI = 5'(FIRST_IDX + NUM_REGS);

   logic [4:0] idx;
   logic       win;
   logic       unused_byte_lanes;

   assign idx = {1'b0, adbus[5:2]};
   assign win = (adbus & MATCH_MASK) == (BASE_ADDR & MATCH_MASK);
   assign hit = win && (idx >= IDX_LO) && (idx < IDX_HI);

   // Registers are word-aligned; byte-lane address bits carry no meaning here
   assign unused_byte_lanes = ^adbus[1:0];

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_sel
      assign onehot[g] = hit && (idx == (IDX_LO + 5'(g)));
   end

endmodule

// File: rtl/dma_creg_bank.sv
// DMA control-register bank on a 4-phase req/ack bus; top register is CTRL (start/IEN/DONE).
// Latency: ack 1 clk after req on a window hit, held while req=1, dropped 1 clk after req falls.
// Backpressure: no new transfer accepted until back in IDLE. Build option: DMA_CREG_RDBACK_EN.
module dma_creg_bank
   import dma_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = DMA_DEF_BASE_ADDR,
   parameter logic [31:0] MATCH_MASK = DMA_DEF_MATCH_MASK,
   parameter int          NUM_REGS   = 4,
   parameter int          FIRST_IDX  = 12,
   parameter int          DATA_W     = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [31:0]                adbus,
   input  logic [DATA_W-1:0]          wdata,
   input  logic                       req,
   input  logic                       we,
   output logic                       ack,
   output logic [DATA_W-1:0]          rdata,
   output logic                       active,
   output logic [NUM_REGS-1:0]        select,
   output logic [NUM_REGS*DATA_W-1:0] cregs,
   input  logic                       busy_i,
   input  logic                       done_i,
   output logic                       start_o,
   output logic                       irq_o
);

   localparam int CTRL_IDX = NUM_REGS - 1;

   creg_state_t          state;
   creg_state_t          state_nxt;
   logic                 hit;
   logic [NUM_REGS-1:0]  onehot;
   logic                 accept;
   logic                 wr_ok;
   logic [DATA_W-1:0]    data_q [CTRL_IDX];
   logic [DATA_W-1:0]    ctrl_q;
   logic [DATA_W-1:0]    ctrl_nxt;
   logic                 start_nxt;
   logic                 irq_nxt;

   dma_win_decode #(
      .BASE_ADDR  (BASE_ADDR),
      .MATCH_MASK (MATCH_MASK),
      .NUM_REGS   (NUM_REGS),
      .FIRST_IDX  (FIRST_IDX)
   ) u_dec (
      .adbus  (adbus),
      .hit    (hit),
      .onehot (onehot)
   );

   assign active = hit;
   assign accept = (state == ST_IDLE) && req && hit;
   // Writes while the engine runs are acked but discarded
   assign wr_ok  = accept && we && !busy_i;
   assign ack    = (state == ST_ACK);

   // Handshake state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Handshake next state: accept on hit, release once req is withdrawn
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (req && hit) state_nxt = ST_ACK;
         ST_ACK:  if (!req)       state_nxt = ST_IDLE;
         default:                 state_nxt = ST_IDLE;
      endcase
   end

   // Latch which register the accepted transfer addressed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      select <= '0;
      else if (accept) select <= onehot;
   end

   // Plain r/w registers below CTRL
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CTRL_IDX; i++) data_q[i] <= '0;
      end else if (wr_ok) begin
         for (int i = 0; i < CTRL_IDX; i++) begin
            if (onehot[i]) data_q[i] <= wdata;
         end
      end
   end

   // CTRL update: START never stored, DONE is W1C but a same-cycle done_i wins
   always_comb begin
      ctrl_nxt  = ctrl_q;
      start_nxt = 1'b0;
      if (wr_ok && onehot[CTRL_IDX]) begin
         ctrl_nxt             = wdata;
         ctrl_nxt[CTRL_START] = 1'b0;
         ctrl_nxt[CTRL_DONE]  = ctrl_q[CTRL_DONE] & ~wdata[CTRL_DONE];
         start_nxt            = wdata[CTRL_START];
      end
      if (done_i) ctrl_nxt[CTRL_DONE] = 1'b1;
   end

   assign irq_nxt = ctrl_nxt[CTRL_DONE] & ctrl_nxt[CTRL_IEN];

   // CTRL register, start pulse and interrupt level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q  <= '0;
         start_o <= 1'b0;
         irq_o   <= 1'b0;
      end else begin
         ctrl_q  <= ctrl_nxt;
         start_o <= start_nxt;
         irq_o   <= irq_nxt;
      end
   end

   for (genvar g = 0; g < CTRL_IDX; g++) begin : g_flat
      assign cregs[g*DATA_W +: DATA_W] = data_q[g];
   end
   assign cregs[CTRL_IDX*DATA_W +: DATA_W] = ctrl_q;

`ifdef DMA_CREG_RDBACK_EN
   logic [DATA_W-1:0] rd_mux;

   // Read mux over the decoded index; CTRL bit0 is stored as 0 so reads see 0
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < CTRL_IDX; i++) begin
         if (onehot[i]) rd_mux = data_q[i];
      end
      if (onehot[CTRL_IDX]) rd_mux = ctrl_q;
   end

   // Capture read data on the accept edge so it is stable for the whole ack phase
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             rdata <= '0;
      else if (accept && !we) rdata <= rd_mux;
   end
`else
   assign rdata = '0;
`endif

endmodule

// File: tb/tb_dma_creg_bank.sv
// Directed bench for dma_creg_bank: stimulus queues expected ack responses, a monitor checks them.
// Latency: expects ack one clock after req, release one clock after req drops.
// Backpressure: holds req until ack, then drops it and waits for ack to clear.
module tb_dma_creg_bank;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [31:0]  adbus = '0;
   logic [31:0]  wdata = '0;
   logic         req = 1'b0;
   logic         we = 1'b0;
   logic         ack;
   logic [31:0]  rdata;
   logic         active;
   logic [3:0]   select;
   logic [127:0] cregs;
   logic         busy_i = 1'b0;
   logic         done_i = 1'b0;
   logic         start_o;
   logic         irq_o;

   typedef struct {
      bit          chk_rd;
      logic [31:0] rd;
      logic [3:0]  sel;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad = 0;
   int   start_cnt = 0;
   logic ack_prev = 1'b0;

`ifdef DMA_CREG_RDBACK_EN
   localparam logic [31:0] RB_MASK = 32'hFFFF_FFFF;
`else
   localparam logic [31:0] RB_MASK = 32'h0;
`endif

   localparam logic [31:0] A_R0   = 32'hAFFF_FFF0;
   localparam logic [31:0] A_R1   = 32'hAFFF_FFF4;
   localparam logic [31:0] A_R2   = 32'hAFFF_FFF8;
   localparam logic [31:0] A_CTRL = 32'hAFFF_FFFC;

   dma_creg_bank u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .adbus   (adbus),
      .wdata   (wdata),
      .req     (req),
      .we      (we),
      .ack     (ack),
      .rdata   (rdata),
      .active  (active),
      .select  (select),
      .cregs   (cregs),
      .busy_i  (busy_i),
      .done_i  (done_i),
      .start_o (start_o),
      .irq_o   (irq_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rb(input logic [31:0] v);
      return v & RB_MASK;
   endfunction

   function automatic logic [31:0] creg(input int i);
      return cregs[i*32 +: 32];
   endfunction

   function automatic exp_t mk(input bit c, input logic [31:0] r, input logic [3:0] s);
      exp_t e;
      e.chk_rd = c;
      e.rd     = r;
      e.sel    = s;
      return e;
   endfunction

   // Monitor: every rising ack must match the oldest queued expectation
   always @(negedge clk) begin
      if (start_o) start_cnt++;
      if (ack && !ack_prev) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_ack", 64'd1, 64'd0);
         end else begin
            mon_e = sb_q.pop_front();
            chk("sb_select", 64'(select), 64'(mon_e.sel));
            if (mon_e.chk_rd) chk("sb_rdata", 64'(rdata), 64'(mon_e.rd));
         end
      end
      ack_prev = ack;
   end

   // Full 4-phase transfer with latency checks; optional done_i on the accept edge
   task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input bit chk_rd, input logic [31:0] exp_rd, input logic [3:0] exp_sel,
                       input bit with_done);
      int n;
      sb_q.push_back(mk(chk_rd, exp_rd, exp_sel));
      @(negedge clk);
      adbus = a; we = w; wdata = d; req = 1'b1;
      if (with_done) done_i = 1'b1;
      @(posedge clk); #1;
      n = 0;
      while (!ack && n < 20) begin @(posedge clk); #1; n++; end
      chk("ack_latency", 64'(n), 64'd0);
      @(negedge clk);
      done_i = 1'b0; req = 1'b0;
      n = 0;
      while (ack && n < 20) begin @(posedge clk); #1; n++; end
      chk("ack_release", 64'(n), 64'd1);
   endtask

   task automatic no_ack(input logic [31:0] a, input string name);
      int n;
      @(negedge clk);
      adbus = a; we = 1'b0; req = 1'b1;
      #1 chk({name, "_active"}, 64'(active), 64'd0);
      n = 0;
      repeat (10) begin @(posedge clk); #1; if (ack) n++; end
      chk({name, "_noack"}, 64'(n), 64'd0);
      @(negedge clk);
      req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int s0;
      int n;
      #3;
      chk("rst_ack", 64'(ack), 64'd0);
      chk("rst_cregs", 64'(|cregs), 64'd0);
      chk("rst_irq", 64'(irq_o), 64'd0);
      chk("rst_select", 64'(select), 64'd0);
      chk("rst_rdata", 64'(rdata), 64'd0);
      chk("rst_active_addr0", 64'(active), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Plain register writes and reads, including ignored byte-lane bits
      xfer(A_R0, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 4'b0001, 1'b0);
      chk("w_r0", 64'(creg(0)), 64'h1234_5678);
      chk("w_r0_select", 64'(select), 64'b0001);
      xfer(A_R1, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h0, 4'b0010, 1'b0);
      chk("w_r1", 64'(creg(1)), 64'hCAFE_F00D);
      chk("w_r1_keeps_r0", 64'(creg(0)), 64'h1234_5678);
      xfer(A_R0, 1'b0, 32'h0, 1'b1, rb(32'h1234_5678), 4'b0001, 1'b0);
      xfer(32'hAFFF_FFF7, 1'b0, 32'h0, 1'b1, rb(32'hCAFE_F00D), 4'b0010, 1'b0);
      @(negedge clk); adbus = 32'hAFFF_FFFF; req = 1'b0;
      #1 chk("active_top_idx", 64'(active), 64'd1);

      // CTRL: start pulse and IEN
      s0 = start_cnt;
      xfer(A_CTRL, 1'b1, 32'h3, 1'b0, 32'h0, 4'b1000, 1'b0);
      chk("start_pulse", 64'(start_cnt - s0), 64'd1);
      chk("ctrl_ien", 64'(creg(3)), 64'h2);
      chk("irq_off", 64'(irq_o), 64'd0);
      xfer(A_CTRL, 1'b0, 32'h0, 1'b1, rb(32'h2), 4'b1000, 1'b0);

      // done_i sets DONE and raises irq
      @(negedge clk); done_i = 1'b1;
      @(negedge clk); done_i = 1'b0;
      @(posedge clk); #1;
      chk("ctrl_done", 64'(creg(3)), 64'h6);
      chk("irq_on", 64'(irq_o), 64'd1);

      // W1C of DONE keeps IEN
      s0 = start_cnt;
      xfer(A_CTRL, 1'b1, 32'h6, 1'b0, 32'h0, 4'b1000, 1'b0);
      chk("ctrl_w1c", 64'(creg(3)), 64'h2);
      chk("irq_cleared", 64'(irq_o), 64'd0);
      chk("no_start_w1c", 64'(start_cnt - s0), 64'd0);

      // done_i coincident with W1C: set wins
      @(negedge clk); done_i = 1'b1;
      @(negedge clk); done_i = 1'b0;
      xfer(A_CTRL, 1'b1, 32'h6, 1'b0, 32'h0, 4'b1000, 1'b1);
      chk("ctrl_set_wins", 64'(creg(3)), 64'h6);
      chk("irq_set_wins", 64'(irq_o), 64'd1);

      // Writes while busy are acked and dropped
      busy_i = 1'b1;
      s0 = start_cnt;
      xfer(A_CTRL, 1'b1, 32'h1, 1'b0, 32'h0, 4'b1000, 1'b0);
      xfer(A_R0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0, 4'b0001, 1'b0);
      chk("busy_no_start", 64'(start_cnt - s0), 64'd0);
      chk("busy_ctrl_kept", 64'(creg(3)), 64'h6);
      chk("busy_r0_kept", 64'(creg(0)), 64'h1234_5678);
      busy_i = 1'b0;

      // Out-of-range and off-window addresses are ignored
      no_ack(32'hAFFF_FFC0, "idx0");
      no_ack(32'hAFFF_FFEC, "idx11");
      no_ack(32'h1000_0000, "offwin");

      // Reset mid-handshake, req held through reset
      sb_q.push_back(mk(1'b0, 32'h0, 4'b0100));
      sb_q.push_back(mk(1'b0, 32'h0, 4'b0100));
      @(negedge clk);
      adbus = A_R2; we = 1'b1; wdata = 32'h55; req = 1'b1;
      @(posedge clk); #1;
      chk("mid_ack", 64'(ack), 64'd1);
      chk("mid_r2", 64'(creg(2)), 64'h55);
      chk("mid_irq", 64'(irq_o), 64'd1);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ack", 64'(ack), 64'd0);
      chk("mid_rst_cregs", 64'(|cregs), 64'd0);
      chk("mid_rst_irq", 64'(irq_o), 64'd0);
      chk("mid_rst_select", 64'(select), 64'd0);
      wdata = 32'hAA;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      n = 0;
      while (!ack && n < 20) begin @(posedge clk); #1; n++; end
      chk("reack_latency", 64'(n), 64'd0);
      chk("reack_r2", 64'(creg(2)), 64'hAA);
      @(negedge clk); req = 1'b0;
      n = 0;
      while (ack && n < 20) begin @(posedge clk); #1; n++; end
      chk("reack_release", 64'(n), 64'd1);

      repeat (2) @(negedge clk);
      chk("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
